// File: rtl/iob_cache_arb2.sv
// ---------------------------------------------------------------------------
// iob_cache_arb2
//
// Two-master to one-slave arbiter between the L1 back-ends (master 0 =
// instruction side, master 1 = data side) and the L2 front-end.
//
// One transaction is in flight at a time. A three-state FSM walks through:
//   IDLE : pick a winner among valid masters, capture its request into the
//          slave-side registers.
//   REQ  : present the captured request to L2 until s_ready is seen, then
//          capture s_rdata into the winner's rdata register.
//   RESP : pulse the winner's ready for one cycle, then return to IDLE.
//
// Every output is driven straight from a flop, so there is no combinational
// path from any master input to the slave outputs, nor from the slave inputs
// to the master outputs.
//
// Ports
//   clk                  : single clock, all state on the rising edge
//   reset                : asynchronous, active-low reset
//   m0_valid/addr/wdata/wstrb -> m0_ready/rdata : master 0 (L1 instruction)
//   m1_valid/addr/wdata/wstrb -> m1_ready/rdata : master 1 (L1 data)
//   s_valid/addr/wdata/wstrb  <- s_ready/rdata  : request to / response from L2
//
// Parameters
//   ADDR_W : word-address width below the select MSB (address ports ADDR_W+1)
//   DATA_W : data width (strobe width DATA_W/8)
//
// Build option
//   IOB_CACHE_ARB_FIXED_PRIO_EN : when defined, simultaneous requests always
//   go to master 1 (data side). When undefined, ties alternate round-robin
//   using a last-grant pointer.
// ---------------------------------------------------------------------------
module iob_cache_arb2 #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  m0_valid,
    input  logic [ADDR_W:0]       m0_addr,
    input  logic [DATA_W-1:0]     m0_wdata,
    input  logic [DATA_W/8-1:0]   m0_wstrb,
    output logic                  m0_ready,
    output logic [DATA_W-1:0]     m0_rdata,

    input  logic                  m1_valid,
    input  logic [ADDR_W:0]       m1_addr,
    input  logic [DATA_W-1:0]     m1_wdata,
    input  logic [DATA_W/8-1:0]   m1_wstrb,
    output logic                  m1_ready,
    output logic [DATA_W-1:0]     m1_rdata,

    output logic                  s_valid,
    output logic [ADDR_W:0]       s_addr,
    output logic [DATA_W-1:0]     s_wdata,
    output logic [DATA_W/8-1:0]   s_wstrb,
    input  logic                  s_ready,
    input  logic [DATA_W-1:0]     s_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                state_q,    state_d;
    logic                  grant_q,    grant_d;     // 0 = master 0, 1 = master 1
    logic                  s_valid_q,  s_valid_d;
    logic [ADDR_W:0]       s_addr_q,   s_addr_d;
    logic [DATA_W-1:0]     s_wdata_q,  s_wdata_d;
    logic [DATA_W/8-1:0]   s_wstrb_q,  s_wstrb_d;
    logic                  m0_ready_q, m0_ready_d;
    logic                  m1_ready_q, m1_ready_d;
    logic [DATA_W-1:0]     m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0]     m1_rdata_q, m1_rdata_d;

    // Winner selection for the current IDLE evaluation.
    logic                  win_m1;

`ifdef IOB_CACHE_ARB_FIXED_PRIO_EN
    // Data side always wins a tie; master 0 only wins when alone.
    assign win_m1 = m1_valid;
`else
    // Last-grant pointer: resets to master 1 so master 0 wins the first tie.
    // It only moves when a transaction is accepted by L2 (REQ -> RESP).
    logic                  last_q,     last_d;

    assign win_m1 = m1_valid & (~m0_valid | ~last_q);
`endif

    // -----------------------------------------------------------------------
    // Next-state and datapath logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        s_valid_d  = s_valid_q;
        s_addr_d   = s_addr_q;
        s_wdata_d  = s_wdata_q;
        s_wstrb_d  = s_wstrb_q;
        m0_ready_d = 1'b0;
        m1_ready_d = 1'b0;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
`ifndef IOB_CACHE_ARB_FIXED_PRIO_EN
        last_d     = last_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // s_ready is ignored here; only master requests matter.
                if (m0_valid || m1_valid) begin
                    grant_d   = win_m1;
                    s_valid_d = 1'b1;
                    if (win_m1) begin
                        s_addr_d  = m1_addr;
                        s_wdata_d = m1_wdata;
                        s_wstrb_d = m1_wstrb;
                    end else begin
                        s_addr_d  = m0_addr;
                        s_wdata_d = m0_wdata;
                        s_wstrb_d = m0_wstrb;
                    end
                    state_d = ST_REQ;
                end
            end

            ST_REQ: begin
                // The request is held in the s_* registers; mX_valid is no
                // longer looked at, so a latched request always completes.
                if (s_ready) begin
                    s_valid_d = 1'b0;
                    if (grant_q) begin
                        m1_rdata_d = s_rdata;
                        m1_ready_d = 1'b1;
                    end else begin
                        m0_rdata_d = s_rdata;
                        m0_ready_d = 1'b1;
                    end
`ifndef IOB_CACHE_ARB_FIXED_PRIO_EN
                    last_d  = grant_q;
`endif
                    state_d = ST_RESP;
                end
            end

            ST_RESP: begin
                // Ready pulse is visible during this single cycle; the
                // defaults above clear it on the way back to IDLE.
                state_d = ST_IDLE;
            end

            default: begin
                state_d   = ST_IDLE;
                s_valid_d = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= 1'b0;
            s_valid_q  <= 1'b0;
            s_addr_q   <= '0;
            s_wdata_q  <= '0;
            s_wstrb_q  <= '0;
            m0_ready_q <= 1'b0;
            m1_ready_q <= 1'b0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            s_valid_q  <= s_valid_d;
            s_addr_q   <= s_addr_d;
            s_wdata_q  <= s_wdata_d;
            s_wstrb_q  <= s_wstrb_d;
            m0_ready_q <= m0_ready_d;
            m1_ready_q <= m1_ready_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

`ifndef IOB_CACHE_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Outputs come straight from flops
    // -----------------------------------------------------------------------
    assign s_valid  = s_valid_q;
    assign s_addr   = s_addr_q;
    assign s_wdata  = s_wdata_q;
    assign s_wstrb  = s_wstrb_q;
    assign m0_ready = m0_ready_q;
    assign m1_ready = m1_ready_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;

endmodule

// File: tb/tb_iob_cache_arb2.sv
// ---------------------------------------------------------------------------
// tb_iob_cache_arb2
//
// Directed bench for iob_cache_arb2 with default parameters. Inputs change
// 1 time unit after the rising edge; outputs are checked at that same
// offset, i.e. well away from the active edge.
// ---------------------------------------------------------------------------
module tb_iob_cache_arb2;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic                  clk;
    logic                  reset;
    logic                  m0_valid, m1_valid;
    logic [ADDR_W:0]       m0_addr, m1_addr;
    logic [DATA_W-1:0]     m0_wdata, m1_wdata;
    logic [DATA_W/8-1:0]   m0_wstrb, m1_wstrb;
    logic                  m0_ready, m1_ready;
    logic [DATA_W-1:0]     m0_rdata, m1_rdata;
    logic                  s_valid;
    logic [ADDR_W:0]       s_addr;
    logic [DATA_W-1:0]     s_wdata;
    logic [DATA_W/8-1:0]   s_wstrb;
    logic                  s_ready;
    logic [DATA_W-1:0]     s_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    iob_cache_arb2 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .m0_valid (m0_valid),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_wstrb (m0_wstrb),
        .m0_ready (m0_ready),
        .m0_rdata (m0_rdata),
        .m1_valid (m1_valid),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_wstrb (m1_wstrb),
        .m1_ready (m1_ready),
        .m1_rdata (m1_rdata),
        .s_valid  (s_valid),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_wstrb  (s_wstrb),
        .s_ready  (s_ready),
        .s_rdata  (s_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic            exp_m;
        logic [31:0]     last_m0_rdata;
        logic [ADDR_W:0] exp_addr;

        m0_valid = 0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
        m1_valid = 0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        s_ready  = 0; s_rdata = '0;
        reset    = 0;

        // ---------------- Reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_valid",  s_valid,  0);
        check("rst_m0_ready", m0_ready, 0);
        check("rst_m1_ready", m1_ready, 0);
        check("rst_s_addr",   s_addr,   0);
        check("rst_s_wdata",  s_wdata,  0);
        check("rst_s_wstrb",  s_wstrb,  0);
        check("rst_m0_rdata", m0_rdata, 0);
        check("rst_m1_rdata", m1_rdata, 0);
        reset = 1;
        tick();
        $display("step: reset checked");

        // ---------------- Single m0 read ----------------
        m0_valid = 1; m0_addr = 33'h10; m0_wstrb = 4'h0; m0_wdata = 32'h0;
        tick();
        check("rd_s_valid_t1", s_valid,  1);
        check("rd_s_addr",     s_addr,   33'h10);
        check("rd_s_wstrb",    s_wstrb,  0);
        check("rd_m0_ready_0", m0_ready, 0);
        m0_valid = 0;                       // latched request must still finish
        tick();
        check("rd_s_valid_hold1", s_valid, 1);
        tick();
        check("rd_s_valid_hold2", s_valid, 1);
        s_ready = 1; s_rdata = 32'hDEADBEEF;
        tick();
        check("rd_m0_ready",   m0_ready, 1);
        check("rd_m0_rdata",   m0_rdata, 32'hDEADBEEF);
        check("rd_m1_ready",   m1_ready, 0);
        check("rd_s_valid_lo", s_valid,  0);
        s_ready = 0; s_rdata = 32'h0;
        tick();
        check("rd_m0_ready_once", m0_ready, 0);
        check("rd_m1_ready_end",  m1_ready, 0);
        check("rd_m0_rdata_hold", m0_rdata, 32'hDEADBEEF);
        $display("step: single m0 read done");

        // ---------------- Tie arbitration, 4 transactions ----------------
        reset = 0;
        tick();
        reset = 1;
        check("rr_rst_m0_rdata", m0_rdata, 0);
        last_m0_rdata = 32'h0;
        m0_valid = 1; m0_addr = 33'h100; m0_wdata = 32'h1111_0000;
        m1_valid = 1; m1_addr = 33'h200; m1_wdata = 32'h2222_0000;
        for (int k = 0; k < 4; k++) begin
`ifdef IOB_CACHE_ARB_FIXED_PRIO_EN
            exp_m = 1'b1;
`else
            exp_m = k[0];
`endif
            exp_addr = exp_m ? 33'h200 : 33'h100;
            tick();
            check("rr_s_valid", s_valid, 1);
            check("rr_s_addr",  s_addr,  exp_addr);
            s_ready = 1; s_rdata = 32'hA000 + k;
            tick();
            check("rr_m0_ready", m0_ready, !exp_m);
            check("rr_m1_ready", m1_ready, exp_m);
            if (exp_m) check("rr_m1_rdata", m1_rdata, 32'hA000 + k);
            else begin
                check("rr_m0_rdata", m0_rdata, 32'hA000 + k);
                last_m0_rdata = 32'hA000 + k;
            end
            s_ready = 0;
            tick();
            check("rr_m0_ready_lo", m0_ready, 0);
            check("rr_m1_ready_lo", m1_ready, 0);
            $display("step: tie txn %0d granted m%0d addr=%0h", k, exp_m, s_addr);
        end
        m0_valid = 0; m1_valid = 0;

        // ---------------- m1 write with long stall ----------------
        m1_valid = 1; m1_addr = 33'h20; m1_wdata = 32'h12345678; m1_wstrb = 4'hF;
        tick();
        check("wr_s_valid", s_valid, 1);
        check("wr_s_addr",  s_addr,  33'h20);
        check("wr_s_wdata", s_wdata, 32'h12345678);
        check("wr_s_wstrb", s_wstrb, 4'hF);
        // Disturb the master side; the slave side must not follow.
        m1_valid = 0; m1_addr = 33'h1_FFFF_FFFF; m1_wdata = 32'h0BAD_0BAD; m1_wstrb = 4'h3;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("wr_stall_s_valid", s_valid,  1);
            check("wr_stall_s_addr",  s_addr,   33'h20);
            check("wr_stall_s_wdata", s_wdata,  32'h12345678);
            check("wr_stall_s_wstrb", s_wstrb,  4'hF);
            check("wr_stall_m1_rdy",  m1_ready, 0);
        end
        s_ready = 1; s_rdata = 32'hCAFEF00D;
        tick();
        check("wr_m1_ready",      m1_ready, 1);
        check("wr_m1_rdata",      m1_rdata, 32'hCAFEF00D);
        check("wr_m0_ready",      m0_ready, 0);
        check("wr_m0_rdata_hold", m0_rdata, last_m0_rdata);
        s_ready = 0;
        tick();
        check("wr_m1_ready_once", m1_ready, 0);
        $display("step: m1 write done");

        // ---------------- Reset during REQ ----------------
        m0_valid = 1; m0_addr = 33'h40;
        tick();
        check("rq_s_valid", s_valid, 1);
        m0_valid = 0;
        #2;
        reset = 0;
        #1;
        check("rq_rst_s_valid",  s_valid,  0);
        check("rq_rst_m0_ready", m0_ready, 0);
        check("rq_rst_m1_ready", m1_ready, 0);
        check("rq_rst_s_addr",   s_addr,   0);
        tick();
        reset = 1;
        for (int i = 0; i < 4; i++) begin
            s_ready = (i == 1);             // a stray s_ready must not revive it
            tick();
            check("rq_post_s_valid",  s_valid,  0);
            check("rq_post_m0_ready", m0_ready, 0);
            check("rq_post_m1_ready", m1_ready, 0);
        end
        s_ready = 0;
        $display("step: reset during REQ done");

        // ---------------- s_ready in IDLE / RESP, dropped waiter ----------------
        s_ready = 1;
        tick();
        check("idle_sr_s_valid",  s_valid,  0);
        check("idle_sr_m0_ready", m0_ready, 0);
        check("idle_sr_m1_ready", m1_ready, 0);
        s_ready = 0;
        m0_valid = 1; m0_addr = 33'h300;
        m1_valid = 1; m1_addr = 33'h400;
`ifdef IOB_CACHE_ARB_FIXED_PRIO_EN
        exp_m = 1'b1;
`else
        exp_m = 1'b0;                       // pointer back at master 1 after reset
`endif
        tick();
        check("dw_s_addr", s_addr, exp_m ? 33'h400 : 33'h300);
        m0_valid = 0; m1_valid = 0;         // loser gives up while waiting
        s_ready = 1; s_rdata = 32'h5555_AAAA;
        tick();
        check("dw_m0_ready", m0_ready, !exp_m);
        check("dw_m1_ready", m1_ready, exp_m);
        tick();                             // s_ready still high during RESP
        check("resp_sr_m0_ready", m0_ready, 0);
        check("resp_sr_m1_ready", m1_ready, 0);
        check("resp_sr_s_valid",  s_valid,  0);
        tick();
        check("dw_idle_s_valid",  s_valid,  0);
        check("dw_idle_m0_ready", m0_ready, 0);
        check("dw_idle_m1_ready", m1_ready, 0);
        s_ready = 0;
        $display("step: stray s_ready and dropped waiter done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/iob_cache_arb2.md
IOB_CACHE_ARB2 -- requirements
Module: iob_cache_arb2

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, word-address width below the select MSB; address ports are ADDR_W+1 bits.
REQ-002 SHALL have parameter DATA_W, default 32, data width; strobe width DATA_W/8.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports m0_valid/m0_addr/m0_wdata/m0_wstrb  input  1/ADDR_W+1/DATA_W/DATA_W/8  master 0 request (L1 instruction back-end).
REQ-006 SHALL have ports m0_ready/m0_rdata  output  1/DATA_W  master 0 response.
REQ-007 SHALL have ports m1_valid/m1_addr/m1_wdata/m1_wstrb  input  1/ADDR_W+1/DATA_W/DATA_W/8  master 1 request (L1 data back-end).
REQ-008 SHALL have ports m1_ready/m1_rdata  output  1/DATA_W  master 1 response.
REQ-009 SHALL have ports s_valid/s_addr/s_wdata/s_wstrb  output  1/ADDR_W+1/DATA_W/DATA_W/8  request to L2 front-end.
REQ-010 SHALL have ports s_ready/s_rdata  input  1/DATA_W  L2 response.

Function
REQ-011 SHALL be fully registered in both directions; no combinational path from any m* input to any s* output or from s* inputs to m* outputs.
REQ-012 SHALL implement FSM states IDLE, REQ, RESP.
REQ-013 IDLE: if no mX_valid, stay; else select winner, latch its addr/wdata/wstrb into s_* registers, record grant, go to REQ.
REQ-014 Tie (both valid in IDLE): SHALL grant the master not granted last (round-robin); last-grant pointer updates on REQ->RESP.
REQ-015 REQ: s_valid SHALL be 1 with s_addr/s_wdata/s_wstrb constant until s_ready sampled 1.
REQ-016 REQ with s_ready=1: SHALL latch s_rdata into the granted master's rdata register, drop s_valid next cycle, go to RESP.
REQ-017 RESP: SHALL assert the granted master's ready for exactly one cycle, then go to IDLE; the other master's ready SHALL stay 0.
REQ-018 Latency: request seen in IDLE at cycle t -> s_valid high at t+1; s_ready at cycle u -> mX_ready at u+1.
REQ-019 mX_rdata SHALL hold its last latched value until next response to that master.
REQ-020 Non-granted master SHALL wait with ready=0; its request SHALL be served in the next IDLE evaluation if still valid.
REQ-021 Valid dropped by a master while waiting (not granted) SHALL be ignored; once latched, a request SHALL complete regardless of mX_valid.
REQ-022 Writes (wstrb!=0) and reads SHALL be handled identically; rdata latched for both.
REQ-023 s_ready while in IDLE or RESP SHALL be ignored.

Reset
REQ-024 reset low SHALL immediately force: state IDLE, s_valid=0, m0_ready=m1_ready=0, s_addr/s_wdata/s_wstrb=0, m0_rdata=m1_rdata=0, last-grant=master 1 (so master 0 wins first tie).
REQ-025 Reset mid-REQ SHALL abandon the in-flight transaction; no ready pulse issued after release.

Configuration
REQ-026 Macro IOB_CACHE_ARB_FIXED_PRIO_EN: defined -> ties always granted to master 1 (data), pointer unused; undefined -> round-robin per REQ-014.

Verification
REQ-027 Single m0 read addr=0x10, s_ready 3 cycles after s_valid, s_rdata=0xDEADBEEF -> s_valid cycle t+1, m0_ready exactly 1 cycle after s_ready, m0_rdata=0xDEADBEEF, m1_ready never 1.
REQ-028 m0 and m1 valid same cycle after reset, both held -> order m0, m1, m0, m1 over four transactions (m1,m1,... with IOB_CACHE_ARB_FIXED_PRIO_EN).
REQ-029 m1 write addr=0x20 wdata=0x12345678 wstrb=0xF, s_ready held 0 for 10 cycles -> s_* stable all 10 cycles, m1_ready 0 until s_ready.
REQ-030 reset low during REQ -> s_valid and all ready 0 same cycle; after release with no valid, no ready pulse, s_valid stays 0.
REQ-031 s_ready pulsed during IDLE/RESP -> no state change, no extra ready pulse.
